// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: ALU control codes, MIPS opcode/funct values, decoded entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_issue_pkg;

    // ALU control codes driven onto alu_32bit.op
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLL = 4'b1101;
    localparam logic [3:0] ALU_SRL = 4'b1110;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    // One decoded instruction, exactly what the ALU and write-back need
    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] first;
        logic [31:0] second;
        logic [4:0]  shamt;
        logic [4:0]  dest;
        logic        illegal;
    } entry_t;

    localparam entry_t ENTRY_RESET = '0;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Maps an instruction word plus its rs/rt operands to a decoded ALU entry.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the entry is captured.
import alu_issue_pkg::*;

module alu_issue_decode (
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output entry_t      entry
);

    logic [5:0]  opcode;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic [4:0]  sh_fld;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic        bad;

    assign opcode = instr[31:26];
    assign rt_idx = instr[20:16];
    assign rd_idx = instr[15:11];
    assign sh_fld = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];

    // Decode opcode/funct into op, operands, shift amount and destination
    always_comb begin
        entry         = ENTRY_RESET;
        entry.op      = ALU_ADD;
        bad           = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                entry.first  = rs_data;
                entry.second = rt_data;
                entry.dest   = rd_idx;
                unique case (funct)
                    FN_ADD, FN_ADDU: entry.op = ALU_ADD;
                    FN_SUB, FN_SUBU: entry.op = ALU_SUB;
                    FN_AND:          entry.op = ALU_AND;
                    FN_OR:           entry.op = ALU_OR;
                    FN_NOR:          entry.op = ALU_NOR;
                    FN_SLT:          entry.op = ALU_SLT;
                    FN_SLL, FN_SRL: begin
                        // Shifts operate on rt; the amount comes from the instruction
                        entry.op     = (funct == FN_SLL) ? ALU_SLL : ALU_SRL;
                        entry.first  = rt_data;
                        entry.second = 32'h0;
                        entry.shamt  = sh_fld;
                    end
                    default:         bad = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW: begin
                entry.op     = ALU_ADD;
                entry.first  = rs_data;
                entry.second = sext16(imm);
                entry.dest   = rt_idx;
            end
            OP_SW: begin
                // Address generation only; stores write no register
                entry.op     = ALU_ADD;
                entry.first  = rs_data;
                entry.second = sext16(imm);
            end
            OP_SLTI: begin
                entry.op     = ALU_SLT;
                entry.first  = rs_data;
                entry.second = sext16(imm);
                entry.dest   = rt_idx;
            end
            OP_ANDI: begin
                entry.op     = ALU_AND;
                entry.first  = rs_data;
                entry.second = zext16(imm);
                entry.dest   = rt_idx;
            end
            OP_ORI: begin
                entry.op     = ALU_OR;
                entry.first  = rs_data;
                entry.second = zext16(imm);
                entry.dest   = rt_idx;
            end
            OP_BEQ: begin
                // Compare via subtraction; branch writes no register
                entry.op     = ALU_SUB;
                entry.first  = rs_data;
                entry.second = rt_data;
            end
            default: bad = 1'b1;
        endcase

        // Unsupported encodings still flow downstream, but as a harmless ADD 0+0 to r0
        if (bad) begin
            entry         = ENTRY_RESET;
            entry.op      = ALU_ADD;
            entry.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage feeding alu_32bit; optional 2-entry skid buffer selected by macro ALU_ISSUE_SKID_EN.
// Latency: one cycle from input transfer to out_valid when empty; full throughput of 1/cycle.
// Backpressure: skid build has registered in_ready (low only when full); default build in_ready = !out_valid || out_ready.
import alu_issue_pkg::*;

module alu_issue_stage #(
    parameter int DEPTH_SKID = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs_data,
    input  logic [31:0] in_rt_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_op,
    output logic [31:0] out_first,
    output logic [31:0] out_second,
    output logic [4:0]  out_shamt,
    output logic [4:0]  out_dest,
    output logic        out_illegal
);

    // The skid buffer is built for exactly two entries
    if (DEPTH_SKID != 2) begin : g_bad_depth
        $error("alu_issue_stage: DEPTH_SKID must be 2");
    end

    entry_t dec_entry;
    entry_t head_q, head_d;
    logic   in_xfer;
    logic   out_xfer;

    alu_issue_decode u_decode (
        .instr   (in_instr),
        .rs_data (in_rs_data),
        .rt_data (in_rt_data),
        .entry   (dec_entry)
    );

`ifdef ALU_ISSUE_SKID_EN
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0] state_q, state_d;
    entry_t     tail_q, tail_d;
    logic       in_ready_q, in_ready_d;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign in_xfer   = in_valid && in_ready_q;
    assign out_xfer  = out_valid && out_ready;

    // Next-state and entry movement for the two-slot skid buffer; flush wins over everything
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        head_d  = dec_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        head_d = dec_entry;
                    end else if (in_xfer) begin
                        tail_d  = dec_entry;
                        state_d = ST_FULL;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain can happen
                    if (out_xfer) begin
                        head_d  = tail_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        // Registered ready: decided from the next state, never from out_ready directly
        in_ready_d = (state_d != ST_FULL);
    end

    // Skid buffer state, entries and registered ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            head_q     <= ENTRY_RESET;
            tail_q     <= ENTRY_RESET;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= in_ready_d;
        end
    end
`else
    logic valid_q, valid_d;

    assign out_valid = valid_q;
    assign in_ready  = !valid_q || out_ready;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = valid_q && out_ready;

    // Single pipeline register: load on accept, empty on drain, flush wins
    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (in_xfer) begin
            head_d  = dec_entry;
            valid_d = 1'b1;
        end else if (out_xfer) begin
            valid_d = 1'b0;
        end
    end

    // Pipeline register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            head_q  <= ENTRY_RESET;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
        end
    end
`endif

    assign out_op      = head_q.op;
    assign out_first   = head_q.first;
    assign out_second  = head_q.second;
    assign out_shamt   = head_q.shamt;
    assign out_dest    = head_q.dest;
    assign out_illegal = head_q.illegal;

endmodule
